// File: rtl/mod_addsub_seq.sv
// Limb-serial modular adder/subtractor: res = (a +/- b) mod p, one LIMB-wide
// slice per clock, LSB first, with a start/ready/done handshake.
module mod_addsub_seq #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned LIMB  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] res
);

    localparam int unsigned   NL   = WIDTH / LIMB;
    localparam int unsigned   CW   = (NL > 1) ? $clog2(NL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NL - 1);

    if (WIDTH % LIMB != 0) begin : g_bad_limb
        $error("WIDTH must be a multiple of LIMB");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             op_mode, op_mode_next;
    logic [WIDTH-1:0] op_a, op_a_next;
    logic [WIDTH-1:0] op_b, op_b_next;
    logic [WIDTH-1:0] op_p, op_p_next;
    logic [WIDTH-1:0] s_reg, s_reg_next;
    logic [WIDTH-1:0] t_reg, t_reg_next;
    logic             c1, c1_next;
    logic             c2, c2_next;
    logic [WIDTH-1:0] res_next;
    logic             done_next;
    logic             take;

    logic [LIMB-1:0]       a_k, b_k, p_k;
    logic [LIMB:0]         s_ext, t_ext;
    logic [WIDTH+LIMB-1:0] s_cat, t_cat;

    assign ready = (state != CALC);
    assign take  = start && ready;

    assign a_k = op_a[LIMB-1:0];
    assign b_k = op_b[LIMB-1:0];
    assign p_k = op_p[LIMB-1:0];

    // Bit LIMB of each extended result is the carry (add) or borrow (sub) out.
    always_comb begin
        s_ext = '0;
        t_ext = '0;
        if (op_mode) begin
            s_ext = {1'b0, a_k} - {1'b0, b_k} - {{LIMB{1'b0}}, c1};
            t_ext = {1'b0, s_ext[LIMB-1:0]} + {1'b0, p_k} + {{LIMB{1'b0}}, c2};
        end else begin
            s_ext = {1'b0, a_k} + {1'b0, b_k} + {{LIMB{1'b0}}, c1};
            t_ext = {1'b0, s_ext[LIMB-1:0]} - {1'b0, p_k} - {{LIMB{1'b0}}, c2};
        end
    end

    // New limbs enter at the top so limb 0 ends up at the bottom after NL shifts.
    assign s_cat = {s_ext[LIMB-1:0], s_reg};
    assign t_cat = {t_ext[LIMB-1:0], t_reg};

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        op_mode_next = op_mode;
        op_a_next    = op_a;
        op_b_next    = op_b;
        op_p_next    = op_p;
        s_reg_next   = s_reg;
        t_reg_next   = t_reg;
        c1_next      = c1;
        c2_next      = c2;
        res_next     = res;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                state_next = IDLE;
            end
            CALC: begin
                s_reg_next = s_cat[WIDTH+LIMB-1:LIMB];
                t_reg_next = t_cat[WIDTH+LIMB-1:LIMB];
                op_a_next  = op_a >> LIMB;
                op_b_next  = op_b >> LIMB;
                op_p_next  = op_p >> LIMB;
                c1_next    = s_ext[LIMB];
                c2_next    = t_ext[LIMB];
                cnt_next   = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                done_next  = 1'b1;
                state_next = IDLE;
                if (op_mode) begin
                    res_next = c1 ? t_reg : s_reg;
                end else begin
                    res_next = (!c1 && c2) ? s_reg : t_reg;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (take) begin
            state_next   = CALC;
            cnt_next     = '0;
            c1_next      = 1'b0;
            c2_next      = 1'b0;
            op_mode_next = mode;
            op_a_next    = a;
            op_b_next    = b;
            op_p_next    = p;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op_mode <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            op_p    <= '0;
            s_reg   <= '0;
            t_reg   <= '0;
            c1      <= 1'b0;
            c2      <= 1'b0;
            res     <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            op_mode <= op_mode_next;
            op_a    <= op_a_next;
            op_b    <= op_b_next;
            op_p    <= op_p_next;
            s_reg   <= s_reg_next;
            t_reg   <= t_reg_next;
            c1      <= c1_next;
            c2      <= c2_next;
            res     <= res_next;
            done    <= done_next;
        end
    end

endmodule

// File: doc/mod_addsub_seq.md
Name: mod_addsub_seq

Overview:
- Limb-serial modular adder/subtractor: res = (a + b) mod p or (a - b) mod p, selected per operation.
- Parametrised in operand width and limb width. Processes one limb per clock, so wide SM2 field operands use narrow carry chains.
- Start/ready/done handshake. Feeds the point-arithmetic sequencer as its add/sub primitive.

Parameters:
- WIDTH, 256, operand/modulus width in bits.
- LIMB, 64, bits processed per cycle. WIDTH % LIMB must be 0. NL = WIDTH/LIMB.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Accepted on an edge where start=1 and ready=1.
- mode  in  1  0 = add, 1 = subtract. Sampled at accept.
- a  in  WIDTH  operand, 0 <= a < p. Sampled at accept.
- b  in  WIDTH  operand, 0 <= b < p. Sampled at accept.
- p  in  WIDTH  odd modulus, p > 1. Sampled at accept.
- ready  out  1  high when a start can be accepted.
- done  out  1  one-cycle pulse: res is valid.
- res  out  WIDTH  result. Held until the next done.

Behaviour:
- Reset values: ready=1, done=0, res=0, state=IDLE, limb counter=0, internal carries=0.
- States:
  - IDLE: ready=1. On accept, latch mode/a/b/p, clear the carry/borrow flags and counter, and go to CALC. ready=0 from the accept edge.
  - CALC: lasts exactly NL cycles. Limb k (LSB first, k=0..NL-1) is processed on the k-th CALC cycle.
  - FIN: one cycle. Writes res, pulses done=1 and sets ready=1, then goes to IDLE. A start sampled during FIN is accepted (back-to-back operation).
- CALC, add mode, per limb:
  - s_k = a_k + b_k + c1, with carry-out to c1.
  - t_k = s_k - p_k - c2, with borrow-out to c2.
  - s_k and t_k are stored in WIDTH-bit shift registers.
- CALC, subtract mode, per limb:
  - s_k = a_k - b_k - c1, with borrow-out to c1.
  - t_k = s_k + p_k + c2, with carry-out to c2.
- FIN selection:
  - Add: res = s if (c1==0 and c2==1), i.e. a+b < p as a (WIDTH+1)-bit value. Otherwise res = t.
  - Sub: res = t if c1==1 (a < b). Otherwise res = s.
- Latency: done asserts exactly NL+1 clock edges after the accepting edge (5 for defaults). Throughput is one operation per NL+1 cycles.
- The carry out of the WIDTH-bit sum must be handled. a+b >= 2^WIDTH must reduce correctly, e.g. SM2 p with a, b near p.
- Results are exact for every in-range input pair, including a=b, a=0 and b=0. Out-of-range inputs (a>=p or b>=p) give an unspecified result but must not hang the FSM.
- start while ready=0 is ignored and has no effect on the operation in flight.
- Changes on a/b/p/mode after accept do not affect the result.
- rst mid-operation: on the next edge the block returns to IDLE with done=0, ready=1 and res=0. No done is emitted for the aborted operation.
- rst and start on the same edge: rst wins and the start is not accepted.

Test Plan:
- Add wrap with SM2 p = FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFF, a=p-1, b=1, mode=0 -> res=0. done exactly 5 cycles after accept, ready low in between.
- Add with sum carry-out, SM2 p, a=b=p-1, mode=0 -> res=p-2 (FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF00000000FFFFFFFFFFFFFFFD).
- Subtract: SM2 p, a=0, b=1, mode=1 -> res=p-1. Then a=5, b=3 -> res=2. Then a=b=p-1 -> res=0.
- Parameter sweep WIDTH=16, LIMB=4, p=0xFFF1, 2000 random in-range (a, b, mode) -> res matches the reference model. done always 5 cycles after accept.
- Back-to-back and ignored start: start held high continuously -> a new op is accepted on each FIN cycle. A start pulse mid-CALC with different operands -> in-flight result unchanged and no extra done.
- Reset mid-CALC (cycle 2 of 4) -> next cycle ready=1, done=0, res=0, with no done afterward. A fresh op then completes normally.
